// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared FSM state type and framing constants for the BLE command link.
package remote_comm_pkg;
  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;
  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/uart_byte.sv
// uart_byte: full-duplex 8N1 byte transmitter and receiver, BAUD_DIV clocks per bit.
module uart_byte import remote_comm_pkg::*; #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic       rx_done,
  input  logic       RX
);
  localparam logic [11:0] BIT_LAST   = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST  = 12'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  FRAME_LAST = 4'(FRAME_BITS - 1);
  logic [9:0]  r_tx_sh;
  logic [11:0] r_tx_cnt, r_rx_cnt;
  logic [3:0]  r_tx_bit, r_rx_bit;
  logic        r_tx_busy, r_rx_busy, r_rx_s1, r_rx_s2, r_rx_s3, r_rx_rdy;
  logic [7:0]  r_rx_sh, r_rx_data;
  logic        w_tx_tick, w_rx_smp;
  // TX is the shift register's LSB, so it is a flop output and resets high asynchronously
  assign TX        = r_tx_sh[0];
  assign w_tx_tick = r_tx_busy && r_tx_cnt == BIT_LAST;
  assign tx_done   = w_tx_tick && r_tx_bit == FRAME_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b0;
    end else if (trmt) begin
      r_tx_sh   <= {1'b1, tx_data, 1'b0};
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_busy <= 1'b1;
    end else if (r_tx_busy) begin
      r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + 12'd1;
      if (w_tx_tick) begin
        r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
        r_tx_bit  <= r_tx_bit + 4'd1;
        r_tx_busy <= !tx_done;
      end
    end
  end
  // first sample lands mid start bit, later ones a full bit apart
  assign w_rx_smp = r_rx_busy && r_rx_cnt == (r_rx_bit == 4'd0 ? HALF_LAST : BIT_LAST);
  assign rx_done  = w_rx_smp && r_rx_bit == FRAME_LAST && r_rx_s2;
  assign rx_data  = r_rx_data;
  assign rx_rdy   = r_rx_rdy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_s3   <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_rx_rdy  <= 1'b0;
    end else begin
      r_rx_s1  <= RX;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_rdy <= !clr_rx_rdy && (rx_done || r_rx_rdy);
      if (rx_done) r_rx_data <= r_rx_sh;
      if (!r_rx_busy) begin
        r_rx_busy <= r_rx_s3 && !r_rx_s2;
        r_rx_cnt  <= '0;
        r_rx_bit  <= '0;
      end else begin
        r_rx_cnt <= w_rx_smp ? '0 : r_rx_cnt + 12'd1;
        if (w_rx_smp) begin
          r_rx_bit  <= r_rx_bit + 4'd1;
          r_rx_busy <= r_rx_bit != FRAME_LAST;
          if (r_rx_bit != FRAME_LAST) r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
        end
      end
    end
  end
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first), then waits for a one-byte reply.
// Optional response timeout enabled by defining REMOTE_TIMEOUT_EN.
module remote_comm import remote_comm_pkg::*; #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 4194304
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        resp_tmo,
  output logic        TX,
  input  logic        RX
);
  state_t      r_state, w_nxt;
  logic [15:0] r_cmd;
  logic        r_cmd_snt;
  logic        w_trmt, w_clr, w_snt, w_tmo, w_tx_done, w_rx_done;
  logic [7:0]  w_tx_data;
  uart_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (w_tx_data),
    .trmt       (w_trmt),
    .tx_done    (w_tx_done),
    .TX         (TX),
    .rx_data    (resp),
    .rx_rdy     (resp_rdy),
    .clr_rx_rdy (w_clr),
    .rx_done    (w_rx_done),
    .RX         (RX)
  );
  always_comb begin
    w_nxt     = r_state;
    w_trmt    = 1'b0;
    w_clr     = 1'b0;
    w_snt     = 1'b0;
    w_tx_data = r_cmd[7:0];
    case (r_state)
      IDLE: if (snd_cmd) begin
        w_nxt     = TX_HI;
        w_trmt    = 1'b1;
        w_clr     = 1'b1;
        w_tx_data = cmd[15:8];
      end
      TX_HI: if (w_tx_done) begin
        w_nxt  = TX_LO;
        w_trmt = 1'b1;
      end
      TX_LO: if (w_tx_done) begin
        w_nxt = WAIT_RESP;
        w_snt = 1'b1;
      end
      WAIT_RESP: w_nxt = (w_rx_done || w_tmo) ? IDLE : WAIT_RESP;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_cmd_snt <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cmd     <= (r_state == IDLE && snd_cmd) ? cmd : r_cmd;
      r_cmd_snt <= w_snt;
    end
  end
  assign busy    = r_state != IDLE;
  assign cmd_snt = r_cmd_snt;
`ifdef REMOTE_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_resp_tmo;
  assign w_tmo    = r_state == WAIT_RESP && r_tmo_cnt == 32'(TIMEOUT_CLKS - 1);
  assign resp_tmo = r_resp_tmo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt  <= '0;
      r_resp_tmo <= 1'b0;
    end else begin
      r_tmo_cnt  <= (r_state == WAIT_RESP) ? r_tmo_cnt + 32'd1 : '0;
      r_resp_tmo <= w_tmo && !w_rx_done;
    end
  end
`else
  assign w_tmo    = 1'b0;
  assign resp_tmo = 1'b0;
`endif
endmodule
